// File: rtl/sdram_axi_burst_bridge_if.sv
// AXI4 slave channels plus the SDRAM controller request/ack/data signals
// seen by the burst bridge; slave = bridge side, master = AXI master + controller side.
interface sdram_axi_burst_bridge_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 23,
  parameter int ID_W   = 1
);
  logic [ID_W-1:0]   s_axi_awid;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [7:0]        s_axi_awlen;
  logic [1:0]        s_axi_awburst;
  logic              s_axi_awvalid, s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata;
  logic              s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid, s_axi_bready;
  logic [ID_W-1:0]   s_axi_arid;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_arvalid, s_axi_arready;
  logic [ID_W-1:0]   s_axi_rid;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic              init_end;
  logic              sdram_wr_req, sdram_wr_ack, sdram_wr_end;
  logic [ADDR_W-1:0] sdram_wr_addr;
  logic [8:0]        sdram_wr_len;
  logic [DATA_W-1:0] sdram_wr_data;
  logic              sdram_rd_req, sdram_rd_ack, sdram_rd_end;
  logic [ADDR_W-1:0] sdram_rd_addr;
  logic [8:0]        sdram_rd_len;
  logic [DATA_W-1:0] sdram_rd_data;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready,
    input  init_end,
    output sdram_wr_req, sdram_wr_addr, sdram_wr_len, sdram_wr_data,
    input  sdram_wr_ack, sdram_wr_end,
    output sdram_rd_req, sdram_rd_addr, sdram_rd_len,
    input  sdram_rd_ack, sdram_rd_data, sdram_rd_end
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready,
    output init_end,
    input  sdram_wr_req, sdram_wr_addr, sdram_wr_len, sdram_wr_data,
    output sdram_wr_ack, sdram_wr_end,
    input  sdram_rd_req, sdram_rd_addr, sdram_rd_len,
    output sdram_rd_ack, sdram_rd_data, sdram_rd_end
  );
endinterface

// File: rtl/sdram_axi_burst_bridge.sv
// AXI4 INCR-burst slave to SDRAM controller bridge: one transaction at a time,
// round-robin AW/AR arbitration, row-boundary splitting, write/read data FIFOs.
//
// state     | meaning
// IDLE      | wait for init_end, arbitrate AW/AR, 1-cycle ready pulse
// W_COLLECT | accept W beats into the write FIFO until wlast
// W_ISSUE   | sdram_wr_req high until first wr_ack
// W_WAIT    | wait wr_end, then next sub-burst or response
// B_RESP    | B channel valid until bready
// R_ISSUE   | sdram_rd_req once read FIFO has room for the sub-burst
// R_WAIT    | wait rd_end, then next sub-burst or drain
// R_DRAIN   | wait for the rlast handshake
module sdram_axi_burst_bridge #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 23,
  parameter int ID_W      = 1,
  parameter int COL_W     = 9,
  parameter int MAX_BURST = 16
) (
  input logic sys_clk,
  input logic sys_rst,
  sdram_axi_burst_bridge_if.slave bus
);
  localparam int PW = $clog2(MAX_BURST);
  localparam int LW = (COL_W + 1 > 9) ? COL_W + 1 : 9;

  typedef enum logic [2:0] {
    IDLE, W_COLLECT, W_ISSUE, W_WAIT, B_RESP, R_ISSUE, R_WAIT, R_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic              last_wr_q, last_wr_d, awready_q, awready_d, arready_q, arready_d;
  logic              err_q, err_d, rdone_q, rdone_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        rem_q, rem_d, len_q, len_d, beat_q, beat_d;

  logic [DATA_W-1:0] wmem [MAX_BURST];
  logic [DATA_W-1:0] rmem [MAX_BURST];
  logic [PW-1:0]     wwp_q, wrp_q, rwp_q, rrp_q;
  logic [PW:0]       wcnt_q, rcnt_q;
  logic              wpush, wpop, rpush, rpop, w_hs, r_hs, rvalid, rlast, wready;

  logic [LW-1:0]     room, rem_w, sub_w, rfree;
  logic [8:0]        sub_len;

  // Sub-burst never crosses a row: clip to the words left in the current row.
  assign room    = LW'(2**COL_W) - LW'(addr_q[COL_W-1:0]);
  assign rem_w   = LW'(rem_q);
  assign sub_w   = (rem_w < room) ? rem_w : room;
  assign sub_len = sub_w[8:0];
  assign rfree   = LW'(MAX_BURST) - LW'(rcnt_q);

  assign wready = (state_q == W_COLLECT) && (wcnt_q != (PW+1)'(MAX_BURST));
  assign w_hs   = bus.s_axi_wvalid && wready;
  assign wpush  = w_hs && !err_q;
  assign wpop   = bus.sdram_wr_ack && (state_q == W_ISSUE || state_q == W_WAIT) && (wcnt_q != '0);
  assign rpush  = bus.sdram_rd_ack && (state_q == R_ISSUE || state_q == R_WAIT);
  assign rvalid = err_q ? (state_q == R_DRAIN) : (rcnt_q != '0);
  assign r_hs   = rvalid && bus.s_axi_rready;
  assign rpop   = r_hs && (rcnt_q != '0);
  assign rlast  = rvalid && (beat_q == len_q - 9'd1);

  assign bus.s_axi_awready = awready_q;
  assign bus.s_axi_arready = arready_q;
  assign bus.s_axi_wready  = wready;
  assign bus.s_axi_bvalid  = (state_q == B_RESP);
  assign bus.s_axi_bid     = id_q;
  assign bus.s_axi_bresp   = (state_q == B_RESP && err_q) ? 2'b10 : 2'b00;
  assign bus.s_axi_rvalid  = rvalid;
  assign bus.s_axi_rlast   = rlast;
  assign bus.s_axi_rid     = id_q;
  assign bus.s_axi_rdata   = err_q ? '0 : rmem[rrp_q];
  assign bus.s_axi_rresp   = (rvalid && err_q) ? 2'b10 : 2'b00;
  assign bus.sdram_wr_req  = (state_q == W_ISSUE);
  assign bus.sdram_wr_addr = addr_q;
  assign bus.sdram_wr_len  = sub_len;
  assign bus.sdram_wr_data = wmem[wrp_q];
  assign bus.sdram_rd_req  = (state_q == R_ISSUE) && (rfree >= sub_w);
  assign bus.sdram_rd_addr = addr_q;
  assign bus.sdram_rd_len  = sub_len;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    awready_d = 1'b0;
    arready_d = 1'b0;
    err_d     = err_q;
    rdone_d   = rdone_q;
    id_d      = id_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    len_d     = len_q;
    beat_d    = beat_q;
    if (r_hs) begin
      beat_d = beat_q + 9'd1;
      if (rlast) rdone_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (awready_q) begin
          if (bus.s_axi_awvalid) begin
            id_d    = bus.s_axi_awid;
            addr_d  = bus.s_axi_awaddr;
            len_d   = {1'b0, bus.s_axi_awlen} + 9'd1;
            rem_d   = len_d;
            err_d   = (bus.s_axi_awburst != 2'b01);
            state_d = W_COLLECT;
          end
        end else if (arready_q) begin
          if (bus.s_axi_arvalid) begin
            id_d    = bus.s_axi_arid;
            addr_d  = bus.s_axi_araddr;
            len_d   = {1'b0, bus.s_axi_arlen} + 9'd1;
            rem_d   = len_d;
            beat_d  = '0;
            rdone_d = 1'b0;
            err_d   = (bus.s_axi_arburst != 2'b01);
            state_d = (bus.s_axi_arburst != 2'b01) ? R_DRAIN : R_ISSUE;
          end
        end else if (bus.init_end) begin
          if (bus.s_axi_awvalid && (!bus.s_axi_arvalid || !last_wr_q)) begin
            awready_d = 1'b1;
            last_wr_d = 1'b1;
          end else if (bus.s_axi_arvalid) begin
            arready_d = 1'b1;
            last_wr_d = 1'b0;
          end
        end
      end
      W_COLLECT: if (w_hs && bus.s_axi_wlast) state_d = err_q ? B_RESP : W_ISSUE;
      W_ISSUE:   if (bus.sdram_wr_ack) state_d = W_WAIT;
      W_WAIT: begin
        if (bus.sdram_wr_end) begin
          rem_d   = rem_q - sub_len;
          addr_d  = addr_q + ADDR_W'(sub_len);
          state_d = (rem_d != '0) ? W_ISSUE : B_RESP;
        end
      end
      B_RESP:  if (bus.s_axi_bready) state_d = IDLE;
      R_ISSUE: if (bus.sdram_rd_ack) state_d = R_WAIT;
      R_WAIT: begin
        if (bus.sdram_rd_end) begin
          rem_d   = rem_q - sub_len;
          addr_d  = addr_q + ADDR_W'(sub_len);
          state_d = (rem_d != '0) ? R_ISSUE : R_DRAIN;
        end
      end
      // rlast may already have been taken while still waiting for rd_end.
      R_DRAIN: if (rdone_q || (r_hs && rlast)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      err_q     <= 1'b0;
      rdone_q   <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      wwp_q     <= '0;
      wrp_q     <= '0;
      rwp_q     <= '0;
      rrp_q     <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      err_q     <= err_d;
      rdone_q   <= rdone_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      if (wpush) wwp_q <= wwp_q + PW'(1);
      if (wpop)  wrp_q <= wrp_q + PW'(1);
      if (rpush) rwp_q <= rwp_q + PW'(1);
      if (rpop)  rrp_q <= rrp_q + PW'(1);
      wcnt_q <= wcnt_q + (PW+1)'(wpush) - (PW+1)'(wpop);
      rcnt_q <= rcnt_q + (PW+1)'(rpush) - (PW+1)'(rpop);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wpush) wmem[wwp_q] <= bus.s_axi_wdata;
    if (rpush) rmem[rwp_q] <= bus.sdram_rd_data;
  end
endmodule

// File: tb/tb_sdram_axi_burst_bridge.sv
// Randomized bench: AXI master tasks, behavioural SDRAM controller, and a
// word-level reference memory plus row-split request model.
module tb_sdram_axi_burst_bridge;
  localparam int BUDGET = 400;
  localparam int MASK   = 32'h7F_FFFF;
  localparam int ROW    = 512;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   model_last_wr = 1'b0;

  int unsigned exp_wr_q[$];
  int unsigned exp_rd_q[$];
  bit          grant_q[$];
  logic [15:0] ref_mem [int];
  logic [15:0] cmem    [int];

  sdram_axi_burst_bridge_if #(.DATA_W(16), .ADDR_W(23), .ID_W(1)) bus ();

  sdram_axi_burst_bridge #(
    .DATA_W(16), .ADDR_W(23), .ID_W(1), .COL_W(9), .MAX_BURST(16)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a & MASK) ? ref_mem[a & MASK] : 16'h0;
  endfunction

  function automatic logic [15:0] cmem_rd(input int a);
    return cmem.exists(a & MASK) ? cmem[a & MASK] : 16'h0;
  endfunction

  // Expected controller requests: consecutive pieces, none crossing a 512-word row.
  function automatic void split_push(input int addr, input int n, input bit wr);
    int a = addr;
    int rem = n;
    int room, l;
    while (rem > 0) begin
      room = ROW - (a % ROW);
      l    = (rem < room) ? rem : room;
      if (wr) exp_wr_q.push_back(int'(a * ROW + l));
      else    exp_rd_q.push_back(int'(a * ROW + l));
      a   = (a + l) & MASK;
      rem = rem - l;
    end
  endfunction

  always @(negedge sys_clk) begin
    if (bus.s_axi_awready) grant_q.push_back(1'b1);
    if (bus.s_axi_arready) grant_q.push_back(1'b0);
  end

  // Behavioural SDRAM controller.
  initial begin : ctrl
    int unsigned e;
    logic [22:0] a;
    int l;
    bit aborted;
    bus.sdram_wr_ack = 0; bus.sdram_wr_end = 0;
    bus.sdram_rd_ack = 0; bus.sdram_rd_end = 0; bus.sdram_rd_data = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) continue;
      if (bus.sdram_wr_req) begin
        a = bus.sdram_wr_addr; l = int'(bus.sdram_wr_len);
        if (exp_wr_q.size() == 0) check_val("wr_unexpected", {a, 9'(l)}, 0);
        else begin e = exp_wr_q.pop_front(); check_val("wr_req", {a, 9'(l)}, 64'(e)); end
        aborted = 0;
        for (int i = 0; i < l; i++) begin
          if (sys_rst) begin aborted = 1; break; end
          bus.sdram_wr_ack = 1;
          cmem[(int'(a) + i) & MASK] = bus.sdram_wr_data;
          @(negedge sys_clk);
        end
        bus.sdram_wr_ack = 0;
        if (!aborted && !sys_rst) begin bus.sdram_wr_end = 1; @(negedge sys_clk); bus.sdram_wr_end = 0; end
      end else if (bus.sdram_rd_req) begin
        a = bus.sdram_rd_addr; l = int'(bus.sdram_rd_len);
        if (exp_rd_q.size() == 0) check_val("rd_unexpected", {a, 9'(l)}, 0);
        else begin e = exp_rd_q.pop_front(); check_val("rd_req", {a, 9'(l)}, 64'(e)); end
        aborted = 0;
        for (int i = 0; i < l; i++) begin
          if (sys_rst) begin aborted = 1; break; end
          bus.sdram_rd_ack  = 1;
          bus.sdram_rd_data = cmem_rd(int'(a) + i);
          @(negedge sys_clk);
        end
        bus.sdram_rd_ack = 0;
        if (!aborted && !sys_rst) begin bus.sdram_rd_end = 1; @(negedge sys_clk); bus.sdram_rd_end = 0; end
      end
    end
  end

  task automatic do_write(input logic [22:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic id, input bit seq);
    int n = int'(len) + 1;
    int cnt;
    bit got;
    logic [15:0] d;
    if (burst == 2'b01) split_push(int'(addr), n, 1);
    bus.s_axi_awaddr = addr; bus.s_axi_awlen = len; bus.s_axi_awburst = burst;
    bus.s_axi_awid = id; bus.s_axi_awvalid = 1;
    cnt = 0;
    while (!bus.s_axi_awready && cnt < BUDGET) begin @(negedge sys_clk); cnt++; end
    if (cnt >= BUDGET) begin check_val("aw_timeout", 1, 0); bus.s_axi_awvalid = 0; return; end
    @(negedge sys_clk);
    bus.s_axi_awvalid = 0;
    for (int i = 0; i < n; i++) begin
      d = seq ? 16'(i) : 16'($urandom);
      if (burst == 2'b01) ref_mem[(int'(addr) + i) & MASK] = d;
      bus.s_axi_wdata = d; bus.s_axi_wlast = (i == n - 1); bus.s_axi_wvalid = 1;
      cnt = 0;
      while (!bus.s_axi_wready && cnt < BUDGET) begin @(negedge sys_clk); cnt++; end
      if (cnt >= BUDGET) begin check_val("w_timeout", i, n); bus.s_axi_wvalid = 0; return; end
      @(negedge sys_clk);
    end
    bus.s_axi_wvalid = 0; bus.s_axi_wlast = 0;
    cnt = 0; got = 0;
    while (!got && cnt < BUDGET) begin
      bus.s_axi_bready = 1'($urandom % 2);
      if (bus.s_axi_bvalid && bus.s_axi_bready) begin
        got = 1;
        check_val("bresp", bus.s_axi_bresp, (burst == 2'b01) ? 2'b00 : 2'b10);
        check_val("bid", bus.s_axi_bid, id);
      end
      @(negedge sys_clk); cnt++;
    end
    bus.s_axi_bready = 0;
    if (!got) check_val("b_timeout", 1, 0);
    else check_val("wr_req_left", exp_wr_q.size(), 0);
  endtask

  task automatic do_read(input logic [22:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic id);
    int n = int'(len) + 1;
    int cnt, k;
    logic [15:0] exp_d[$];
    for (int i = 0; i < n; i++) exp_d.push_back((burst == 2'b01) ? ref_rd(int'(addr) + i) : 16'h0);
    if (burst == 2'b01) split_push(int'(addr), n, 0);
    bus.s_axi_araddr = addr; bus.s_axi_arlen = len; bus.s_axi_arburst = burst;
    bus.s_axi_arid = id; bus.s_axi_arvalid = 1;
    cnt = 0;
    while (!bus.s_axi_arready && cnt < BUDGET) begin @(negedge sys_clk); cnt++; end
    if (cnt >= BUDGET) begin check_val("ar_timeout", 1, 0); bus.s_axi_arvalid = 0; return; end
    @(negedge sys_clk);
    bus.s_axi_arvalid = 0;
    k = 0; cnt = 0;
    while (k < n && cnt < BUDGET) begin
      bus.s_axi_rready = 1'($urandom % 2);
      if (bus.s_axi_rvalid && bus.s_axi_rready) begin
        check_val("rdata", bus.s_axi_rdata, exp_d[k]);
        check_val("rresp", bus.s_axi_rresp, (burst == 2'b01) ? 2'b00 : 2'b10);
        check_val("rlast", bus.s_axi_rlast, 1'(k == n - 1));
        check_val("rid", bus.s_axi_rid, id);
        k++;
      end
      @(negedge sys_clk); cnt++;
    end
    bus.s_axi_rready = 0;
    if (k < n) check_val("r_timeout", k, n);
    else check_val("rd_req_left", exp_rd_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_flags"}, {bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready, bus.s_axi_bvalid,
               bus.s_axi_rvalid, bus.s_axi_rlast, bus.s_axi_bresp, bus.s_axi_rresp, bus.s_axi_bid,
               bus.s_axi_rid, bus.sdram_wr_req, bus.sdram_rd_req}, 0);
    check_val({tag, "_wr_addr_len"}, {bus.sdram_wr_addr, bus.sdram_wr_len}, 0);
    check_val({tag, "_rd_addr_len"}, {bus.sdram_rd_addr, bus.sdram_rd_len}, 0);
  endtask

  task automatic pair(input logic [22:0] wa, input logic [22:0] ra, input string tag);
    bit first_w;
    first_w = !model_last_wr;
    grant_q.delete();
    fork
      do_write(wa, 8'd7, 2'b01, 1'b1, 0);
      do_read(ra, 8'd15, 2'b01, 1'b0);
    join
    if (grant_q.size() != 2) check_val({tag, "_grant_count"}, grant_q.size(), 2);
    else check_val({tag, "_grant_order"}, {grant_q[0], grant_q[1]}, {first_w, !first_w});
    model_last_wr = !first_w;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [22:0] a;
    logic [7:0]  l;
    logic [1:0]  b;
    int cnt;
    bus.s_axi_awid = 0; bus.s_axi_awaddr = 0; bus.s_axi_awlen = 0; bus.s_axi_awburst = 0; bus.s_axi_awvalid = 0;
    bus.s_axi_wdata = 0; bus.s_axi_wlast = 0; bus.s_axi_wvalid = 0; bus.s_axi_bready = 0;
    bus.s_axi_arid = 0; bus.s_axi_araddr = 0; bus.s_axi_arlen = 0; bus.s_axi_arburst = 0; bus.s_axi_arvalid = 0;
    bus.s_axi_rready = 0; bus.init_end = 0;
    repeat (3) @(negedge sys_clk);
    check_outputs_zero("reset");
    sys_rst = 0;
    repeat (2) @(negedge sys_clk);
    bus.init_end = 1;
    @(negedge sys_clk);

    do_write(23'h000100, 8'd15, 2'b01, 1'b0, 1); model_last_wr = 1;
    do_read (23'h000100, 8'd15, 2'b01, 1'b1);    model_last_wr = 0;
    do_write(23'h0001FA, 8'd15, 2'b01, 1'b1, 0); model_last_wr = 1;
    do_read (23'h0001FA, 8'd15, 2'b01, 1'b0);    model_last_wr = 0;

    pair(23'h004000, 23'h000100, "pair1");
    do_read(23'h0001F0, 8'd9, 2'b01, 1'b1); model_last_wr = 0;
    pair(23'h005000, 23'h004000, "pair2");

    do_write(23'h000300, 8'd3, 2'b10, 1'b1, 0); model_last_wr = 1;
    do_read (23'h000300, 8'd3, 2'b00, 1'b1);    model_last_wr = 0;
    do_read (23'h000300, 8'd3, 2'b01, 1'b0);    model_last_wr = 0;

    do_write(23'h7FFFF8, 8'd15, 2'b01, 1'b0, 0); model_last_wr = 1;
    do_read (23'h7FFFF8, 8'd15, 2'b01, 1'b1);    model_last_wr = 0;

    for (int t = 0; t < 12; t++) begin
      if ($urandom % 2 == 1) a = 23'($urandom);
      else a = 23'(($urandom_range(0, 255) * ROW) + ROW - $urandom_range(1, 12));
      l = 8'($urandom_range(0, 15));
      b = ($urandom % 6 == 0) ? 2'b10 : 2'b01;
      do_write(a, l, b, 1'($urandom), 0); model_last_wr = 1;
      do_read(a, l, ($urandom % 6 == 0) ? 2'b11 : 2'b01, 1'($urandom)); model_last_wr = 0;
    end

    // Reset in the middle of a read sub-burst.
    split_push(32'h600, 16, 0);
    bus.s_axi_araddr = 23'h000600; bus.s_axi_arlen = 8'd15; bus.s_axi_arburst = 2'b01;
    bus.s_axi_arid = 1'b1; bus.s_axi_arvalid = 1;
    cnt = 0;
    while (!bus.s_axi_arready && cnt < BUDGET) begin @(negedge sys_clk); cnt++; end
    @(negedge sys_clk);
    bus.s_axi_arvalid = 0;
    cnt = 0;
    while (!bus.sdram_rd_req && cnt < BUDGET) begin @(negedge sys_clk); cnt++; end
    check_val("t6_rd_req_seen", bus.sdram_rd_req, 1);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1;
    #1;
    check_outputs_zero("mid_reset");
    exp_rd_q.delete();
    model_last_wr = 0;
    bus.init_end = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 0;
    grant_q.delete();
    fork
      do_write(23'h000700, 8'd4, 2'b01, 1'b0, 0);
      begin
        repeat (8) @(negedge sys_clk);
        check_val("no_grant_before_init", grant_q.size(), 0);
        bus.init_end = 1;
      end
    join
    model_last_wr = 1;
    do_read(23'h000700, 8'd4, 2'b01, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
